// File: rtl/sccb_cmd_sequencer_if.sv
// Bus bundle for sccb_cmd_sequencer: the PS host write port and the shared SCCB master port.
//   master : sequencer side (drives host_ready/host_done, sccb_req/sccb_send_data,
//            init_done, err_count; samples host_valid/host_data and sccb_busy)
//   slave  : environment side (host and SCCB master), directions mirrored
interface sccb_cmd_sequencer_if;
  logic        host_valid;
  logic [23:0] host_data;
  logic        host_ready;
  logic        host_done;
  logic        sccb_req;
  logic [23:0] sccb_send_data;
  logic        sccb_busy;
  logic        init_done;
  logic [7:0]  err_count;

  modport master (
    input  host_valid, host_data, sccb_busy,
    output host_ready, host_done, sccb_req, sccb_send_data, init_done, err_count
  );

  modport slave (
    output host_valid, host_data, sccb_busy,
    input  host_ready, host_done, sccb_req, sccb_send_data, init_done, err_count
  );
endinterface

// File: rtl/sccb_cmd_sequencer.sv
// Sequences every SCCB register write onto the camera configuration bus. After reset the boot
// table is replayed, then single-entry host writes are served. Each write is started with a
// one-cycle sccb_req, accepted on a rising sccb_busy (retried on timeout), completed on the
// falling sccb_busy and followed by SETTLE_CYCLES idle cycles.
// Ports:
//   clk   : system clock (12 MHz domain)
//   n_rst : asynchronous active-low reset
//   bus   : sccb_cmd_sequencer_if.master (host write port + SCCB master port + status)
// Build option: define SCCB_INIT_TABLE_EN to include the boot-table player; without it
// init_done is tied high and INIT_LEN / INIT_TABLE are ignored.
module sccb_cmd_sequencer #(
  parameter int unsigned           INIT_LEN       = 2,
  parameter logic [24*INIT_LEN-1:0] INIT_TABLE    = {24'h42_11_01, 24'h42_12_80},
  parameter int unsigned           SETTLE_CYCLES  = 12000,
  parameter int unsigned           ACCEPT_TIMEOUT = 255
) (
  input logic                  clk,
  input logic                  n_rst,
  sccb_cmd_sequencer_if.master bus
);

  localparam int unsigned ToW  = $clog2(ACCEPT_TIMEOUT + 2);
  localparam int unsigned SetW = $clog2(SETTLE_CYCLES + 2);

  if (INIT_LEN < 1 || INIT_LEN > 64 || $bits(INIT_TABLE) != 24 * INIT_LEN) begin : g_bad_cfg
    $error("sccb_cmd_sequencer: INIT_LEN must be 1..64 with a matching INIT_TABLE width");
  end

  typedef enum logic [2:0] {StIdle, StIssue, StWaitHi, StWaitLo, StSettle} state_e;

  state_e          state_q, state_d;
  logic [23:0]     hbuf_q, hbuf_d;
  logic            full_q, full_d;
  logic [23:0]     word_q, word_d;
  logic            req_q, req_d;
  logic            done_q, done_d;
  logic [7:0]      err_q, err_d;
  logic [ToW-1:0]  to_cnt_q, to_cnt_d;
  logic [SetW-1:0] set_cnt_q, set_cnt_d;

`ifdef SCCB_INIT_TABLE_EN
  logic        init_done_q, init_done_d;
  logic [5:0]  init_idx_q, init_idx_d;
  logic        src_host_q, src_host_d;
  logic [23:0] boot_word;

  assign boot_word = INIT_TABLE[24*init_idx_q +: 24];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      init_done_q <= 1'b0;
      init_idx_q  <= '0;
      src_host_q  <= 1'b0;
    end else begin
      init_done_q <= init_done_d;
      init_idx_q  <= init_idx_d;
      src_host_q  <= src_host_d;
    end
  end

  assign bus.init_done = init_done_q;
`else
  assign bus.init_done = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    hbuf_d    = hbuf_q;
    full_d    = full_q;
    word_d    = word_q;
    done_d    = 1'b0;
    err_d     = err_q;
    to_cnt_d  = to_cnt_q;
    set_cnt_d = set_cnt_q;
`ifdef SCCB_INIT_TABLE_EN
    init_done_d = init_done_q;
    init_idx_d  = init_idx_q;
    src_host_d  = src_host_q;
`endif

    // Capture never collides with the IDLE drain below: host_ready is low while full.
    if (bus.host_valid && !full_q) begin
      full_d = 1'b1;
      hbuf_d = bus.host_data;
    end

    case (state_q)
      StIdle: begin
`ifdef SCCB_INIT_TABLE_EN
        if (!init_done_q) begin
          word_d     = boot_word;
          src_host_d = 1'b0;
          state_d    = StIssue;
        end else
`endif
        if (full_q) begin
          word_d  = hbuf_q;
          full_d  = 1'b0;
          state_d = StIssue;
`ifdef SCCB_INIT_TABLE_EN
          src_host_d = 1'b1;
`endif
        end
      end
      StIssue: begin
        to_cnt_d = '0;
        state_d  = StWaitHi;
      end
      StWaitHi: begin
        // busy wins over a simultaneous timeout
        if (bus.sccb_busy) begin
          state_d = StWaitLo;
        end else if (to_cnt_q == ToW'(ACCEPT_TIMEOUT)) begin
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
          state_d = StIssue;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      StWaitLo: begin
        if (!bus.sccb_busy) begin
          set_cnt_d = SetW'(SETTLE_CYCLES);
          state_d   = StSettle;
        end
      end
      StSettle: begin
        if (set_cnt_q == '0) begin
          state_d = StIdle;
`ifdef SCCB_INIT_TABLE_EN
          if (src_host_q) begin
            done_d = 1'b1;
          end else begin
            init_idx_d = init_idx_q + 6'd1;
            if (init_idx_q == 6'(INIT_LEN - 1)) init_done_d = 1'b1;
          end
`else
          done_d = 1'b1;
`endif
        end else begin
          set_cnt_d = set_cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Registered strobe: high exactly while the FSM sits in ISSUE.
    req_d = (state_d == StIssue);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= StIdle;
      hbuf_q    <= '0;
      full_q    <= 1'b0;
      word_q    <= '0;
      req_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= '0;
      to_cnt_q  <= '0;
      set_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      hbuf_q    <= hbuf_d;
      full_q    <= full_d;
      word_q    <= word_d;
      req_q     <= req_d;
      done_q    <= done_d;
      err_q     <= err_d;
      to_cnt_q  <= to_cnt_d;
      set_cnt_q <= set_cnt_d;
    end
  end

  assign bus.host_ready     = ~full_q;
  assign bus.host_done      = done_q;
  assign bus.sccb_req       = req_q;
  assign bus.sccb_send_data = word_q;
  assign bus.err_count      = err_q;

endmodule
